// File: rtl/program_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : program_sequencer_if
//  Purpose  : Switch/button/controller inputs and bus-side outputs of the
//             program sequencer, grouped for connection as one port.
//  Revision : 1.0  initial release
// ============================================================================
interface program_sequencer_if #(
  parameter int WIDTH = 10,
  parameter int AW    = 4
);
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             LDb;
  logic             GOb;
  logic             Ext;
  logic             Done;
  logic [WIDTH-1:0] Q;
  logic             QEN;
  logic [AW-1:0]    PC;
  logic [AW:0]      LEN;
  logic             FULL;
  logic             BUSY;
  logic             HALTED;
  logic             ERR;

  // Switch/controller side: drives the requests, observes the sequencer.
  modport master (
    output MODE, D, LDb, GOb, Ext, Done,
    input  Q, QEN, PC, LEN, FULL, BUSY, HALTED, ERR
  );

  // Sequencer side.
  modport slave (
    input  MODE, D, LDb, GOb, Ext, Done,
    output Q, QEN, PC, LEN, FULL, BUSY, HALTED, ERR
  );
endinterface
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : program_sequencer
//  Purpose  : Loads program words from the switches into a small memory and
//             replays them onto the processor bus on each external-data
//             request; transparent pass-through when idle.
//  Revision : 1.0  initial release
// ============================================================================
module program_sequencer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLKb,
  input  logic          CLRb,
  program_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  state_t           r_state, w_stateNext;
  logic [AW:0]      r_pc, w_pcNext, w_pcPost;
  logic [AW:0]      r_len, w_lenNext;
  logic             r_err, w_errNext;
  logic             r_step, w_stepNext;
  logic             r_ldPrev, r_goPrev;
  logic             w_memWe;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // One-cycle press events: button now low, previously high.
  logic w_ldEv, w_goEv, w_full, w_pcBelowLen;
  assign w_ldEv       = ~bus.LDb & r_ldPrev;
  assign w_goEv       = ~bus.GOb & r_goPrev;
  assign w_full       = (r_len == C_DEPTH);
  assign w_pcBelowLen = (r_pc < r_len);

  // Next-state and next-register logic; Done sees the post-increment PC.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_pcPost    = r_pc;
    w_lenNext   = r_len;
    w_errNext   = r_err;
    w_stepNext  = r_step;
    w_memWe     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.MODE == 2'b01) begin
          w_stateNext = S_LOAD;
          w_lenNext   = '0;
        end else if (w_goEv && bus.MODE[1] && (r_len != '0)) begin
          w_stateNext = S_RUN;
          w_pcNext    = '0;
          w_stepNext  = bus.MODE[0];
          w_errNext   = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.MODE != 2'b01) begin
          w_stateNext = S_IDLE;
        end else if (w_ldEv && !w_full) begin
          w_memWe   = 1'b1;
          w_lenNext = r_len + C_ONE;
        end
      end
      S_RUN: begin
        if (bus.MODE == 2'b00) begin
          w_stateNext = S_IDLE;
        end else if (bus.Ext && !w_pcBelowLen) begin
          // Controller wants another word but the program is exhausted.
          w_errNext   = 1'b1;
          w_stateNext = S_HALT;
        end else begin
          if (bus.Ext) begin
            w_pcPost = r_pc + C_ONE;
          end
          w_pcNext = w_pcPost;
          if (bus.Done) begin
            if (w_pcPost == r_len) begin
              w_stateNext = S_HALT;
            end else if (r_step) begin
              w_stateNext = S_PAUSE;
            end
          end
        end
      end
      S_PAUSE: begin
        if (bus.MODE == 2'b00) begin
          w_stateNext = S_IDLE;
        end else if (w_goEv) begin
          w_stateNext = S_RUN;
          w_stepNext  = bus.MODE[0];
        end
      end
      S_HALT: begin
        if (bus.MODE == 2'b00) begin
          w_stateNext = S_IDLE;
          w_errNext   = 1'b0;
        end else if (w_goEv) begin
          w_stateNext = S_RUN;
          w_pcNext    = '0;
          w_errNext   = 1'b0;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and control registers, updated on the falling clock edge.
  always_ff @(negedge CLKb) begin
    if (!CLRb) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_len    <= '0;
      r_err    <= 1'b0;
      r_step   <= 1'b0;
      r_ldPrev <= 1'b1;
      r_goPrev <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_pc     <= w_pcNext;
      r_len    <= w_lenNext;
      r_err    <= w_errNext;
      r_step   <= w_stepNext;
      r_ldPrev <= bus.LDb;
      r_goPrev <= bus.GOb;
    end
  end

  // Program memory write port; contents survive reset.
  always_ff @(negedge CLKb) begin
    if (w_memWe && CLRb) begin
      r_mem[r_len[AW-1:0]] <= bus.D;
    end
  end

  // Bus data and enable: pass-through when idle, memory word otherwise.
  always_comb begin
    bus.Q   = r_mem[r_pc[AW-1:0]];
    bus.QEN = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.Q   = bus.D;
        bus.QEN = bus.Ext;
      end
      S_RUN: begin
        bus.QEN = bus.Ext & w_pcBelowLen;
      end
      default: begin
        bus.QEN = 1'b0;
      end
    endcase
  end

  assign bus.PC     = r_pc[AW-1:0];
  assign bus.LEN    = r_len;
  assign bus.FULL   = w_full;
  assign bus.BUSY   = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.HALTED = (r_state == S_HALT);
  assign bus.ERR    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_sequencer
//  Purpose  : Directed self-checking bench for program_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_program_sequencer;

  logic CLKb;
  logic CLRb;
  int   checks;
  int   failures;

  program_sequencer_if #(.WIDTH(10), .AW(4)) bus ();

  program_sequencer #(.WIDTH(10), .DEPTH(16), .AW(4)) dut (
    .CLKb (CLKb),
    .CLRb (CLRb),
    .bus  (bus)
  );

  // Falling edges at 5, 15, 25, ...
  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  // Advance past the next active (falling) edge.
  task automatic tick();
    @(negedge CLKb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pressLd(input logic [9:0] d);
    bus.D   = d;
    bus.LDb = 1'b0;
    tick();
    bus.LDb = 1'b1;
    tick();
  endtask

  task automatic pressGo();
    bus.GOb = 1'b0;
    tick();
    bus.GOb = 1'b1;
    tick();
  endtask

  logic [9:0] expWord [16];

  initial begin
    checks    = 0;
    failures  = 0;
    CLRb      = 1'b0;
    bus.MODE  = 2'b00;
    bus.D     = '0;
    bus.LDb   = 1'b1;
    bus.GOb   = 1'b1;
    bus.Ext   = 1'b0;
    bus.Done  = 1'b0;
    tick();
    tick();
    CLRb = 1'b1;

    // Reset state and idle pass-through
    bus.D   = 10'h2A5;
    bus.Ext = 1'b1;
    #1;
    chk("idle_q",    32'(bus.Q), 32'h2A5);
    chk("idle_qen1", 32'(bus.QEN), 32'd1);
    bus.Ext = 1'b0;
    #1;
    chk("idle_qen0", 32'(bus.QEN), 32'd0);
    chk("rst_pc",    32'(bus.PC), 32'd0);
    chk("rst_len",   32'(bus.LEN), 32'd0);
    chk("rst_err",   32'(bus.ERR), 32'd0);
    chk("rst_busy",  32'(bus.BUSY), 32'd0);

    // Load four words, then overfill
    bus.MODE = 2'b01;
    tick();
    pressLd(10'h001);
    pressLd(10'h102);
    pressLd(10'h203);
    pressLd(10'h304);
    chk("len4", 32'(bus.LEN), 32'd4);
    chk("full0", 32'(bus.FULL), 32'd0);
    for (int i = 4; i < 20; i++) pressLd(10'(10'h100 + i));
    chk("len16", 32'(bus.LEN), 32'd16);
    chk("full1", 32'(bus.FULL), 32'd1);

    // Read back the whole memory by running it
    expWord[0] = 10'h001;
    expWord[1] = 10'h102;
    expWord[2] = 10'h203;
    expWord[3] = 10'h304;
    for (int i = 4; i < 16; i++) expWord[i] = 10'(10'h100 + i);
    bus.MODE = 2'b10;
    tick();
    pressGo();
    chk("full_busy", 32'(bus.BUSY), 32'd1);
    chk("full_pc0",  32'(bus.PC), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.Ext = 1'b1;
      #1;
      chk($sformatf("full_q%0d", i), 32'(bus.Q), 32'(expWord[i]));
      chk($sformatf("full_qen%0d", i), 32'(bus.QEN), 32'd1);
      tick();
    end
    bus.Ext  = 1'b0;
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("full_halt", 32'(bus.HALTED), 32'd1);
    bus.MODE = 2'b00;
    tick();

    // Three-word program, continuous run
    bus.MODE = 2'b01;
    tick();
    chk("reload_len0", 32'(bus.LEN), 32'd0);
    pressLd(10'h001);
    pressLd(10'h102);
    pressLd(10'h203);
    chk("len3", 32'(bus.LEN), 32'd3);
    bus.MODE = 2'b10;
    tick();
    pressGo();
    bus.Ext = 1'b1;
    #1;
    chk("run_q0", 32'(bus.Q), 32'h001);
    tick();
    #1;
    chk("run_q1", 32'(bus.Q), 32'h102);
    tick();
    bus.Ext  = 1'b0;
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("run_stay_busy", 32'(bus.BUSY), 32'd1);
    chk("run_pc2",       32'(bus.PC), 32'd2);
    bus.Ext = 1'b1;
    #1;
    chk("run_q2", 32'(bus.Q), 32'h203);
    tick();
    bus.Ext  = 1'b0;
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("run_halted", 32'(bus.HALTED), 32'd1);
    chk("run_pc3",    32'(bus.PC), 32'd3);
    bus.Ext = 1'b1;
    #1;
    chk("run_halt_qen", 32'(bus.QEN), 32'd0);
    bus.Ext = 1'b0;

    // Single-step: Ext and Done coincide on the second word
    bus.MODE = 2'b00;
    tick();
    chk("halt_to_idle", 32'(bus.HALTED), 32'd0);
    bus.MODE = 2'b11;
    pressGo();
    bus.Ext = 1'b1;
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Ext  = 1'b0;
    bus.Done = 1'b0;
    chk("step_pc2",    32'(bus.PC), 32'd2);
    chk("step_busy",   32'(bus.BUSY), 32'd1);
    chk("step_halted", 32'(bus.HALTED), 32'd0);
    bus.Ext = 1'b1;
    #1;
    chk("step_pause_qen", 32'(bus.QEN), 32'd0);
    tick();
    chk("step_pause_pc", 32'(bus.PC), 32'd2);
    bus.Ext = 1'b0;
    pressGo();
    bus.Ext = 1'b1;
    #1;
    chk("step_resume_qen", 32'(bus.QEN), 32'd1);
    chk("step_resume_q",   32'(bus.Q), 32'h203);
    bus.Done = 1'b1;
    tick();
    bus.Ext  = 1'b0;
    bus.Done = 1'b0;
    chk("step_halted2", 32'(bus.HALTED), 32'd1);
    chk("step_pc3",     32'(bus.PC), 32'd3);

    // Running out of words
    bus.MODE = 2'b00;
    tick();
    bus.MODE = 2'b01;
    tick();
    pressLd(10'h0AA);
    pressLd(10'h0BB);
    bus.MODE = 2'b10;
    tick();
    pressGo();
    bus.Ext = 1'b1;
    tick();
    tick();
    #1;
    chk("over_qen", 32'(bus.QEN), 32'd0);
    tick();
    bus.Ext = 1'b0;
    chk("over_err",    32'(bus.ERR), 32'd1);
    chk("over_halted", 32'(bus.HALTED), 32'd1);
    pressGo();
    chk("rerun_err",  32'(bus.ERR), 32'd0);
    chk("rerun_pc",   32'(bus.PC), 32'd0);
    chk("rerun_busy", 32'(bus.BUSY), 32'd1);
    chk("rerun_q",    32'(bus.Q), 32'h0AA);

    // Reset in the middle of a run
    bus.Ext = 1'b1;
    tick();
    bus.Ext = 1'b0;
    chk("mid_pc1", 32'(bus.PC), 32'd1);
    CLRb = 1'b0;
    tick();
    CLRb = 1'b1;
    chk("mrst_busy", 32'(bus.BUSY), 32'd0);
    chk("mrst_pc",   32'(bus.PC), 32'd0);
    chk("mrst_len",  32'(bus.LEN), 32'd0);
    chk("mrst_err",  32'(bus.ERR), 32'd0);
    bus.D   = 10'h155;
    bus.Ext = 1'b1;
    #1;
    chk("mrst_q",   32'(bus.Q), 32'h155);
    chk("mrst_qen", 32'(bus.QEN), 32'd1);
    bus.Ext = 1'b0;

    // GO with an empty program is ignored
    bus.MODE = 2'b10;
    pressGo();
    chk("empty_go", 32'(bus.BUSY), 32'd0);

    // Abort with MODE=00 keeps PC and LEN
    bus.MODE = 2'b01;
    tick();
    pressLd(10'h011);
    pressLd(10'h022);
    pressLd(10'h033);
    bus.MODE = 2'b10;
    tick();
    pressGo();
    bus.Ext = 1'b1;
    tick();
    bus.Ext  = 1'b0;
    bus.MODE = 2'b00;
    tick();
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_pc",   32'(bus.PC), 32'd1);
    chk("abort_len",  32'(bus.LEN), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Sequences the 10-bit processor from a small internal program memory, replacing the live switch value on the shared bus.
- Program words (instructions and immediates) are loaded one at a time from the switches, then played back word-by-word whenever the processor controller requests external data (Ext).
- Instruction completion (the controller's Clr/done) drives run, single-step and halt control.
- In IDLE the block is a transparent pass-through, so manual operation is unchanged.

Parameters:
WIDTH, 10, bus and program word width
DEPTH, 16, program memory words
AW, 4, address width, log2(DEPTH)

Ports:
CLKb  in  1  system clock; all state updates on falling edge
CLRb  in  1  synchronous active-low reset
MODE  in  2  00 manual, 01 load, 10 run, 11 single-step
D  in  WIDTH  switch data; load source and manual pass-through
LDb  in  1  debounced load button, active-low
GOb  in  1  debounced start/continue button, active-low
Ext  in  1  controller request for external bus data this cycle
Done  in  1  controller instruction-complete (Clr)
Q  out  WIDTH  data for the bus driver
QEN  out  1  bus drive enable; parent tristates bus when low
PC  out  AW  next word to be fetched
LEN  out  AW+1  loaded program length, 0..DEPTH
FULL  out  1  LEN==DEPTH
BUSY  out  1  state is RUN or PAUSE
HALTED  out  1  state is HALT
ERR  out  1  sticky: program ran out of words mid-instruction

Behaviour:
- Reset (CLRb low at a falling edge of CLKb):
  - state IDLE, PC=0, LEN=0, ERR=0, step flag 0.
  - LDb/GOb previous-sample registers are set to 1.
  - Memory contents are not cleared.
- Button events: LD_EV = LDb sampled 0 and previous sample 1; GO_EV likewise. Each event lasts exactly one cycle per press.
- States: IDLE, LOAD, RUN, PAUSE, HALT.
- Outputs (combinational from registered state):
  - IDLE: Q=D, QEN=Ext.
  - RUN: Q=mem[PC], QEN=Ext when PC<LEN; QEN=0 when PC==LEN.
  - LOAD, PAUSE, HALT: Q=mem[PC], QEN=0.
- IDLE transitions:
  - MODE=01 -> LOAD, LEN<=0.
  - GO_EV with MODE=10 or 11 and LEN>0 -> RUN, PC<=0, step flag<=MODE[0], ERR<=0.
  - GO_EV with LEN=0 is ignored.
- LOAD:
  - LD_EV with LEN<DEPTH: mem[LEN]<=D, LEN<=LEN+1.
  - LD_EV with FULL is ignored; no wrap.
  - MODE!=01 -> IDLE, LEN retained.
- RUN:
  - Ext with PC<LEN: PC<=PC+1 on that edge. One word is consumed per Ext cycle.
  - Ext with PC==LEN: ERR<=1, -> HALT.
  - Done, evaluated against the post-increment PC when Ext and Done coincide:
    - PC==LEN -> HALT.
    - else if step flag -> PAUSE.
    - else stay in RUN.
  - MODE=00 -> IDLE (abort). Takes priority over all RUN events; PC and LEN are retained.
- PAUSE: GO_EV -> RUN, PC kept, step flag<=MODE[0]. MODE=00 -> IDLE.
- HALT: GO_EV -> RUN with PC<=0 and ERR<=0 (rerun). MODE=00 -> IDLE, ERR cleared.
- MODE changes other than those listed have no effect in RUN, PAUSE or HALT.
- Reset mid-run: next edge forces IDLE and QEN follows IDLE rules immediately.
- PC arithmetic is unsigned AW+1 internally for the compare against LEN. PC never exceeds LEN.

Test Plan:
- Reset, MODE=00, D=10'h2A5, Ext=1 -> Q=10'h2A5, QEN=1; Ext=0 -> QEN=0. PC=0, LEN=0, ERR=0.
- MODE=01, four LD_EV with D=001,102,203,304 -> LEN=4, mem[0..3] match. 16 more presses -> LEN=16, FULL=1, mem[15] unchanged by the 17th+ press.
- Load 3 words. MODE=10, GO_EV, then Ext pulses with Done after words 2 and 3 -> Q sequence 001,102,203; after the final Done, HALTED=1, PC=3, QEN=0.
- MODE=11 with the same program -> PAUSE after the first Done (PC=2, BUSY=1, QEN=0 under Ext); GO_EV resumes; HALT after the second Done.
- Load 2 words, run, assert Ext 3 times before Done -> third Ext gives QEN=0, ERR=1, HALTED=1. GO_EV clears ERR and restarts at PC=0.
- Mid-run, CLRb low one edge -> IDLE, PC=0, LEN=0, ERR=0, QEN=Ext pass-through. Separately, MODE=00 mid-run -> IDLE with PC retained.
